// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN read arbiter: FSM state encoding,
// client index constants and default bus widths.
package cnn_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    // Client indices: picture reader and weight reader
    localparam logic CL_PIC = 1'b0;
    localparam logic CL_WGT = 1'b1;

    // Default widths of the memory-side buses
    localparam int DEFAULT_ADDR_WIDTH   = 19;
    localparam int DEFAULT_MEM_DATA_BUS = 128;

    // With two clients, the "other" client is simply the complement
    function automatic logic other_client(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/cnn_rr_pick.sv
// Two-way round-robin winner selection. Purely combinational:
// a lone requester always wins, on contention the preferred client wins.
module cnn_rr_pick (
    input  logic [1:0] cl_req,
    input  logic       rr_ptr,
    output logic       pick_idx,
    output logic       pick_valid
);

    logic [1:0] win;

    // A client wins if it requests and either the other is idle or it is preferred
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_win
            assign win[gi] = cl_req[gi] & (~cl_req[1 - gi] | (rr_ptr == 1'(gi)));
        end
    endgenerate

    // Exactly one bit of win is set whenever anyone requests
    assign pick_idx   = win[1];
    assign pick_valid = |win;

endmodule

// File: rtl/cnn_rd_arb.sv
// Round-robin read arbiter: two CNN read clients (picture, weight) share
// one downstream memory read port. IDLE -> ISSUE -> DONE -> IDLE, all
// outputs registered.
// Optional feature: define CNN_RD_ARB_TIMEOUT_EN to abandon a grant wait
// after TIMEOUT_CYCLES ISSUE cycles (zero data, normal grant pulse, sticky
// arb_err). Without it ISSUE waits forever and arb_err stays 0.
module cnn_rd_arb
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int MEM_DATA_BUS   = DEFAULT_MEM_DATA_BUS,
    parameter int SIZE_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cl_req,
    input  logic [ADDR_WIDTH-1:0]   cl_addr0,
    input  logic [ADDR_WIDTH-1:0]   cl_addr1,
    input  logic [SIZE_WIDTH-1:0]   cl_size0,
    input  logic [SIZE_WIDTH-1:0]   cl_size1,
    output logic [1:0]              cl_gnt,
    output logic [MEM_DATA_BUS-1:0] cl_data,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_start_addr,
    output logic [SIZE_WIDTH-1:0]   mem_size_bytes,
    input  logic                    mem_gnt,
    input  logic [MEM_DATA_BUS-1:0] mem_data,
    output logic                    arb_busy,
    output logic                    arb_err
);

    arb_state_t              state_reg;
    logic                    rr_ptr_reg;
    logic                    owner_reg;
    logic [1:0]              cl_gnt_reg;
    logic [MEM_DATA_BUS-1:0] cl_data_reg;
    logic                    mem_req_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [SIZE_WIDTH-1:0]   mem_size_reg;
    logic                    arb_busy_reg;
    logic                    arb_err_reg;

    logic                    pick_idx;
    logic                    pick_valid;

    // Client address/size gathered into arrays so the winner index selects them
    logic [ADDR_WIDTH-1:0]   cl_addr_arr [2];
    logic [SIZE_WIDTH-1:0]   cl_size_arr [2];

    assign cl_addr_arr[0] = cl_addr0;
    assign cl_addr_arr[1] = cl_addr1;
    assign cl_size_arr[0] = cl_size0;
    assign cl_size_arr[1] = cl_size1;

    cnn_rr_pick u_pick (
        .cl_req     (cl_req),
        .rr_ptr     (rr_ptr_reg),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

`ifdef CNN_RD_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_reg;
`endif

    // Arbiter FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= CL_PIC;
            owner_reg    <= CL_PIC;
            cl_gnt_reg   <= 2'b00;
            cl_data_reg  <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            mem_size_reg <= '0;
            arb_busy_reg <= 1'b0;
            arb_err_reg  <= 1'b0;
`ifdef CNN_RD_ARB_TIMEOUT_EN
            to_cnt_reg   <= '0;
`endif
        end else begin
            // Grant is a single-cycle pulse unless re-asserted below
            cl_gnt_reg <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_reg    <= pick_idx;
                        mem_addr_reg <= cl_addr_arr[pick_idx];
                        mem_size_reg <= cl_size_arr[pick_idx];
                        mem_req_reg  <= 1'b1;
                        arb_busy_reg <= 1'b1;
                        state_reg    <= ST_ISSUE;
`ifdef CNN_RD_ARB_TIMEOUT_EN
                        to_cnt_reg   <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        cl_data_reg           <= mem_data;
                        mem_req_reg           <= 1'b0;
                        cl_gnt_reg[owner_reg] <= 1'b1;
                        state_reg             <= ST_DONE;
                    end
`ifdef CNN_RD_ARB_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        // Give up: hand back zero data so the client is not stuck
                        cl_data_reg           <= '0;
                        mem_req_reg           <= 1'b0;
                        cl_gnt_reg[owner_reg] <= 1'b1;
                        arb_err_reg           <= 1'b1;
                        state_reg             <= ST_DONE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    rr_ptr_reg   <= other_client(owner_reg);
                    arb_busy_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    mem_req_reg  <= 1'b0;
                    arb_busy_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign cl_gnt         = cl_gnt_reg;
    assign cl_data        = cl_data_reg;
    assign mem_req        = mem_req_reg;
    assign mem_start_addr = mem_addr_reg;
    assign mem_size_bytes = mem_size_reg;
    assign arb_busy       = arb_busy_reg;
    assign arb_err        = arb_err_reg;

endmodule

// File: tb/tb_cnn_rd_arb.sv
// Directed self-checking bench for cnn_rd_arb. Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_cnn_rd_arb;

    localparam int AW = 19;
    localparam int DW = 128;
    localparam int SW = 5;
`ifdef CNN_RD_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cl_req;
    logic [AW-1:0] cl_addr0, cl_addr1;
    logic [SW-1:0] cl_size0, cl_size1;
    logic [1:0]    cl_gnt;
    logic [DW-1:0] cl_data;
    logic          mem_req;
    logic [AW-1:0] mem_start_addr;
    logic [SW-1:0] mem_size_bytes;
    logic          mem_gnt;
    logic [DW-1:0] mem_data;
    logic          arb_busy;
    logic          arb_err;

    int assertions = 0;
    int failures   = 0;

    cnn_rd_arb #(
        .ADDR_WIDTH     (AW),
        .MEM_DATA_BUS   (DW),
        .SIZE_WIDTH     (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cl_req         (cl_req),
        .cl_addr0       (cl_addr0),
        .cl_addr1       (cl_addr1),
        .cl_size0       (cl_size0),
        .cl_size1       (cl_size1),
        .cl_gnt         (cl_gnt),
        .cl_data        (cl_data),
        .mem_req        (mem_req),
        .mem_start_addr (mem_start_addr),
        .mem_size_bytes (mem_size_bytes),
        .mem_gnt        (mem_gnt),
        .mem_data       (mem_data),
        .arb_busy       (arb_busy),
        .arb_err        (arb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cl_req = 2'b00; mem_gnt = 1'b0; mem_data = '0;
        cl_addr0 = '0; cl_addr1 = '0; cl_size0 = '0; cl_size1 = '0;
        tick(); tick();
        assertions++;
        if ({mem_req, cl_gnt, arb_busy, arb_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b gnt=%b busy=%b err=%b, want all 0", mem_req, cl_gnt, arb_busy, arb_err);
        end
        assertions++;
        if (mem_start_addr !== '0 || mem_size_bytes !== '0 || cl_data !== '0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h size=%0d data=%h, want 0", mem_start_addr, mem_size_bytes, cl_data);
        end
        rst = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_single();
        logic [DW-1:0] d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        cl_req = 2'b01; cl_addr0 = 19'h00100; cl_size0 = 5'd4;   // cycle 0
        tick();                                                  // cycle 1
        assertions++;
        if (mem_req !== 1'b1 || mem_start_addr !== 19'h00100 || mem_size_bytes !== 5'd4 || arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_issue: got req=%b addr=%h size=%0d busy=%b, want 1 00100 4 1", mem_req, mem_start_addr, mem_size_bytes, arb_busy);
        end
        assertions++;
        if (cl_gnt !== 2'b00) begin
            failures++;
            $display("FAIL single_nogrant_c1: got gnt=%b want 00", cl_gnt);
        end
        mem_gnt = 1'b1; mem_data = d;
        tick();                                                  // cycle 2
        mem_gnt = 1'b0; mem_data = '0; cl_req = 2'b00;
        assertions++;
        if (cl_gnt !== 2'b01 || cl_data !== d || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b data=%h req=%b, want 01 %h 0", cl_gnt, cl_data, mem_req, d);
        end
        tick();                                                  // cycle 3
        assertions++;
        if (cl_gnt !== 2'b00 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_after: got gnt=%b busy=%b, want 00 0", cl_gnt, arb_busy);
        end
        $display("txn single client0 addr=00100 size=4 gnt=01");
    endtask

    task automatic test_size_zero();
        cl_req = 2'b10; cl_addr1 = 19'h7FFFF; cl_size1 = 5'd0;
        tick();
        assertions++;
        if (mem_req !== 1'b1 || mem_start_addr !== 19'h7FFFF || mem_size_bytes !== 5'd0) begin
            failures++;
            $display("FAIL size_zero_issue: got req=%b addr=%h size=%0d, want 1 7ffff 0", mem_req, mem_start_addr, mem_size_bytes);
        end
        mem_gnt = 1'b1; mem_data = 128'h1;
        tick();
        mem_gnt = 1'b0; cl_req = 2'b00;
        assertions++;
        if (cl_gnt !== 2'b10 || cl_data !== 128'h1) begin
            failures++;
            $display("FAIL size_zero_grant: got gnt=%b data=%h, want 10 1", cl_gnt, cl_data);
        end
        tick();
        $display("txn single client1 addr=7ffff size=0 gnt=10");
    endtask

    task automatic test_contention();
        // rr_ptr is 0 here (last served was client 1); mem_gnt held high,
        // so it is also present outside ISSUE where it must be ignored.
        logic [1:0] exp_gnt;
        int         n = 0;
        cl_req = 2'b11; cl_addr0 = 19'h00111; cl_addr1 = 19'h00222;
        cl_size0 = 5'd8; cl_size1 = 5'd16;
        mem_gnt = 1'b1; mem_data = 128'hA5;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 12) cl_req = 2'b00;
            if (k % 3 == 2) begin
                exp_gnt = (n % 2 == 0) ? 2'b01 : 2'b10;
                n++;
            end else begin
                exp_gnt = 2'b00;
            end
            assertions++;
            if (cl_gnt !== exp_gnt) begin
                failures++;
                $display("FAIL contention_gnt c%0d: got %b want %b", k, cl_gnt, exp_gnt);
            end
            if (k % 3 == 1) begin
                assertions++;
                if (mem_start_addr !== ((n % 2 == 0) ? 19'h00111 : 19'h00222)) begin
                    failures++;
                    $display("FAIL contention_addr c%0d: got %h want %h", k, mem_start_addr, (n % 2 == 0) ? 19'h00111 : 19'h00222);
                end
            end
            $display("txn contention cycle=%0d gnt=%b", k, cl_gnt);
        end
        mem_gnt = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [DW-1:0] d = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        cl_req = 2'b01; cl_addr0 = 19'h00ABC; cl_size0 = 5'd16;
        tick();                                   // first ISSUE cycle
        // Client drops request and changes its address: transfer must continue
        cl_req = 2'b00; cl_addr0 = 19'h12345; cl_size0 = 5'd1;
        for (int k = 1; k <= 10; k++) begin
            assertions++;
            if (mem_req !== 1'b1 || mem_start_addr !== 19'h00ABC || mem_size_bytes !== 5'd16 || cl_gnt !== 2'b00) begin
                failures++;
                $display("FAIL stall_hold c%0d: got req=%b addr=%h size=%0d gnt=%b, want 1 00abc 16 00", k, mem_req, mem_start_addr, mem_size_bytes, cl_gnt);
            end
            tick();
        end
        mem_gnt = 1'b1; mem_data = d;
        tick();
        mem_gnt = 1'b0;
        assertions++;
        if (cl_gnt !== 2'b01 || cl_data !== d || mem_req !== 1'b0 || arb_err !== 1'b0) begin
            failures++;
            $display("FAIL stall_grant: got gnt=%b data=%h req=%b err=%b, want 01 %h 0 0", cl_gnt, cl_data, mem_req, arb_err, d);
        end
        tick();
        $display("txn stall 10 cycles gnt=01");
    endtask

    task automatic test_mid_reset();
        // rr_ptr is 1 here, so without reset client 1 would win
        cl_req = 2'b11; cl_addr0 = 19'h00AAA; cl_addr1 = 19'h00BBB;
        tick();                                   // ISSUE for client 1
        assertions++;
        if (mem_req !== 1'b1 || mem_start_addr !== 19'h00BBB) begin
            failures++;
            $display("FAIL midrst_pre: got req=%b addr=%h, want 1 00bbb", mem_req, mem_start_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        assertions++;
        if (mem_req !== 1'b0 || cl_gnt !== 2'b00 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort: got req=%b gnt=%b busy=%b, want 0 00 0", mem_req, cl_gnt, arb_busy);
        end
        tick();
        assertions++;
        if (mem_req !== 1'b1 || mem_start_addr !== 19'h00AAA || cl_gnt !== 2'b00) begin
            failures++;
            $display("FAIL midrst_restart: got req=%b addr=%h gnt=%b, want 1 00aaa 00", mem_req, mem_start_addr, cl_gnt);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; cl_req = 2'b00;
        assertions++;
        if (cl_gnt !== 2'b01) begin
            failures++;
            $display("FAIL midrst_grant: got gnt=%b want 01", cl_gnt);
        end
        tick();
        $display("txn mid-issue reset then client0 gnt=01");
    endtask

`ifdef CNN_RD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        cl_req = 2'b01; cl_addr0 = 19'h00333; mem_gnt = 1'b0;
        tick();
        cl_req = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            assertions++;
            if (mem_req !== 1'b1 || cl_gnt !== 2'b00) begin
                failures++;
                $display("FAIL timeout_wait c%0d: got req=%b gnt=%b, want 1 00", k, mem_req, cl_gnt);
            end
            tick();
        end
        assertions++;
        if (cl_gnt !== 2'b01 || cl_data !== '0 || arb_err !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: got gnt=%b data=%h err=%b req=%b, want 01 0 1 0", cl_gnt, cl_data, arb_err, mem_req);
        end
        tick(); tick();
        assertions++;
        if (arb_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got err=%b want 1", arb_err);
        end
        $display("txn timeout after 8 cycles err=%b", arb_err);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_size_zero();
        test_contention();
        test_stall();
        test_mid_reset();
`ifdef CNN_RD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
